// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// handshake constants and the operand magnitude helper.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [5:0] DivLastCnt = 6'd32;

  // Two's-complement magnitude for negative signed operands; unsigned passes through.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, 32 iterations, RISC-V divide-by-zero semantics.
// Result is {remainder, quotient}, valid while ready_o is high.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  r_state, w_state_nx;
  logic [5:0]  r_cnt, w_cnt_nx;
  logic [31:0] r_rem, w_rem_nx;
  logic [31:0] r_dividend, w_dividend_nx;
  logic [31:0] r_divisor, w_divisor_nx;
  logic        r_neg_q, w_neg_q_nx;
  logic        r_neg_r, w_neg_r_nx;
  logic [63:0] w_result_nx;
  logic        w_ready_nx;
  logic [32:0] w_trial;

  // r_dividend holds the dividend magnitude and fills with quotient bits as it shifts out.
  assign w_trial = {r_rem, r_dividend[31]} - {1'b0, r_divisor};

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_rem_nx      = r_rem;
    w_dividend_nx = r_dividend;
    w_divisor_nx  = r_divisor;
    w_neg_q_nx    = r_neg_q;
    w_neg_r_nx    = r_neg_r;
    w_result_nx   = result_o;
    w_ready_nx    = ready_o;

    if (annul_i) begin
      w_state_nx  = DivFree;
      w_result_nx = '0;
      w_ready_nx  = DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          w_result_nx = '0;
          w_ready_nx  = DivResultNotReady;
          if (start_i == DivStart) begin
            if (opdata2_i == '0) begin
              w_state_nx    = DivByZero;
              w_dividend_nx = opdata1_i;
            end else begin
              w_state_nx    = DivOn;
              w_cnt_nx      = '0;
              w_rem_nx      = '0;
              w_dividend_nx = div_mag(opdata1_i, signed_div_i);
              w_divisor_nx  = div_mag(opdata2_i, signed_div_i);
              w_neg_q_nx    = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              w_neg_r_nx    = signed_div_i & opdata1_i[31];
            end
          end
        end
        DivByZero: begin
          w_state_nx  = DivEnd;
          w_result_nx = {r_dividend, 32'hFFFF_FFFF};
          w_ready_nx  = DivResultReady;
        end
        DivOn: begin
          if (r_cnt == DivLastCnt) begin
            w_state_nx  = DivEnd;
            w_result_nx = {(r_neg_r ? (~r_rem + 32'd1) : r_rem),
                           (r_neg_q ? (~r_dividend + 32'd1) : r_dividend)};
            w_ready_nx  = DivResultReady;
          end else begin
            w_cnt_nx = r_cnt + 6'd1;
            if (!w_trial[32]) begin
              w_rem_nx      = w_trial[31:0];
              w_dividend_nx = {r_dividend[30:0], 1'b1};
            end else begin
              w_rem_nx      = {r_rem[30:0], r_dividend[31]};
              w_dividend_nx = {r_dividend[30:0], 1'b0};
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            w_state_nx  = DivFree;
            w_result_nx = '0;
            w_ready_nx  = DivResultNotReady;
          end
        end
        default: begin
          w_state_nx  = DivFree;
          w_result_nx = '0;
          w_ready_nx  = DivResultNotReady;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DivFree;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      result_o   <= '0;
      ready_o    <= DivResultNotReady;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_rem      <= w_rem_nx;
      r_dividend <= w_dividend_nx;
      r_divisor  <= w_divisor_nx;
      r_neg_q    <= w_neg_q_nx;
      r_neg_r    <= w_neg_r_nx;
      result_o   <= w_result_nx;
      ready_o    <= w_ready_nx;
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  The single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  Asynchronous, active-low reset: 0 = reset asserted, regardless of the RstEnable define used by combinational stages.
REQ-004 signed_div_i  input  1  1 = signed division (DIV/REM), 0 = unsigned division (DIVU/REMU).
REQ-005 opdata1_i  input  32  Dividend.
REQ-006 opdata2_i  input  32  Divisor.
REQ-007 start_i  input  1  DivStart: the execute stage holds this at 1 until it sees ready_o.
REQ-008 annul_i  input  1  Abort the current operation (pipeline flush or exception).
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 ready_o  output  1  DivResultReady: result_o is valid.

Function
REQ-011 The block SHALL implement four states: FREE, BYZERO, ON, END.
REQ-012 FREE, start_i=1, annul_i=0, divisor 0: the block SHALL go to BYZERO.
REQ-013 FREE, start_i=1, annul_i=0, divisor non-zero: on that edge the block SHALL latch the operand magnitudes, latch the quotient and remainder signs, clear the 6-bit iteration counter, and go to ON.
REQ-014 Operand magnitudes: for signed operations, each negative operand SHALL be converted to two's-complement magnitude (32-bit unsigned); for unsigned operations the operands SHALL be used as-is.
REQ-015 ON SHALL perform one radix-2 restoring step per cycle for 32 cycles: shift {rem, quo} left by 1, trial-subtract the divisor from the upper 33 bits, keep the difference and set quo[0]=1 when it is non-negative.
REQ-016 When the counter reaches 32, the block SHALL apply the sign fix-up and go to END.
- Quotient is negated when signed and the operand signs differ.
- Remainder is negated when signed and the dividend is negative.
REQ-017 BYZERO SHALL go to END on the next edge with quotient = 0xFFFFFFFF and remainder = dividend (RISC-V semantics).
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0 through the normal path, with no special case.
REQ-019 END SHALL drive ready_o=1 and hold result_o stable while start_i=1.
REQ-020 END with start_i=0 SHALL go to FREE on the next edge, with ready_o=0 and result_o=0.
REQ-021 Latency: for a non-zero divisor, ready_o SHALL rise on the 33rd rising edge after the edge that accepted start; for division by zero, on the 2nd edge.
REQ-022 annul_i=1 in any state SHALL force FREE on the next edge, with ready_o=0 and result_o=0; annul_i SHALL take priority over start_i.
REQ-023 ready_o SHALL never be 1 outside END.
REQ-024 result_o SHALL be 0 whenever ready_o=0.
REQ-025 A new start SHALL be accepted only in FREE, so there SHALL be at least one FREE cycle between operations.

Reset
REQ-026 rst=0 SHALL immediately force the following, independent of clk:
- state = FREE
- counter = 0
- result_o = 0
- ready_o = 0
- internal dividend, divisor and sign registers = 0
REQ-027 Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept start_i on the first edge.

Structure
REQ-028 The state encodings (DivFree, DivByZero, DivOn, DivEnd) and the constants DivStart/DivStop and DivResultReady/DivResultNotReady SHALL reside in the shared defines file.
REQ-029 The block SHALL be a single module with no sub-module.
REQ-030 The trial subtractor SHALL be 33 bits wide, and registered outputs SHALL be driven directly from flops.

Verification
REQ-031 Signed 100 / 7, start held high -> ready_o rises 33 edges after acceptance; quotient 0x0000000E, remainder 0x00000002.
REQ-032 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-033 Unsigned 0x12345678 / 0 -> ready_o after 2 edges; quotient 0xFFFFFFFF, remainder 0x12345678.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000; unsigned 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0x0000000F.
REQ-035 annul_i pulsed at the 10th ON cycle -> FREE next edge, ready_o never rises; the next start (unsigned 9 / 3) -> quotient 3, remainder 0.
REQ-036 rst=0 asserted at the 20th ON cycle -> outputs 0 immediately; after release, start with signed 100 / 7 -> correct result after 33 edges; start dropped in END -> ready_o=0 and result_o=0 on the next edge.
